// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the LC-3 memory responder.
//   state_e          - responder FSM states
//   IO_ADDR_DEFAULT  - address decoded as the switch/hex I/O port
//   WAIT_CYCLES_MIN/MAX - legal range of SRAM strobe cycles per access
//   CNT_W            - width of the wait-state down-counter
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
   localparam int          WAIT_CYCLES_MIN = 1;
   localparam int          WAIT_CYCLES_MAX = 7;
   localparam int          CNT_W           = 3;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: datapath-side memory request bus.
//   MAR, MDR   - request address / write data (datapath -> responder)
//   MEM_EN, WE - request valid level and write select
//   MDR_In     - registered read data (responder -> datapath)
//   R          - one-cycle transaction-complete pulse
// Modports: master = datapath control, slave = memory responder.
interface mem_responder_if;
   logic [15:0] MAR;
   logic [15:0] MDR;
   logic        MEM_EN;
   logic        WE;
   logic [15:0] MDR_In;
   logic        R;

   modport master (
      output MAR, MDR, MEM_EN, WE,
      input  MDR_In, R
   );

   modport slave (
      input  MAR, MDR, MEM_EN, WE,
      output MDR_In, R
   );
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter that times SRAM wait states.
//   clk_i      - clock
//   rst_n_i    - asynchronous active-low reset (count -> 0)
//   load_i     - load load_val_i (has priority over decrement)
//   load_val_i - value to load
//   dec_i      - decrement; the count stops at zero
//   zero_o     - count is zero
module mem_wait_counter
   import mem_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the LC-3 MAR/MDR interface.
// Serves read/write requests either from the memory-mapped switch/hex
// I/O port (IO_ADDR, single cycle) or from asynchronous SRAM with a fixed
// number of strobe cycles, and pulses R once per completed transaction.
//   Clk, Reset_al   - clock, asynchronous active-low reset
//   bus (slave)     - MAR/MDR/MEM_EN/WE request, MDR_In/R response
//   Switches        - I/O read source
//   HEX_Data        - I/O write register
//   ADDR            - SRAM address {4'b0, latched MAR}
//   Data_to_SRAM    - SRAM write data (latched MDR)
//   Data_from_SRAM  - SRAM read data
//   CE_N/OE_N/WE_N/UB_N/LB_N - active-low SRAM strobes, registered
module mem_responder
   import mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset_al,
   mem_responder_if.slave   bus,
   input  logic [15:0]      Switches,
   output logic [15:0]      HEX_Data,
   output logic [19:0]      ADDR,
   output logic [15:0]      Data_to_SRAM,
   input  logic [15:0]      Data_from_SRAM,
   output logic             CE_N,
   output logic             OE_N,
   output logic             WE_N,
   output logic             UB_N,
   output logic             LB_N
);

   if ((WAIT_CYCLES < WAIT_CYCLES_MIN) || (WAIT_CYCLES > WAIT_CYCLES_MAX)) begin : g_bad_wait
      $error("mem_responder: WAIT_CYCLES must be within 1..7");
   end

   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_e      state_q;
   logic [15:0] mar_q;
   logic [15:0] mdr_q;
   logic        we_q;
   logic [15:0] mdr_in_q;
   logic [15:0] hex_q;
   logic        r_q;
   logic        ce_n_q;
   logic        oe_n_q;
   logic        we_n_q;

   logic        is_io;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_zero;

   assign is_io    = (bus.MAR == IO_ADDR);
   assign cnt_load = (state_q == ST_IDLE) && bus.MEM_EN && !is_io;
   assign cnt_dec  = (state_q == ST_ACCESS);

   mem_wait_counter u_wait (
      .clk_i      (Clk),
      .rst_n_i    (Reset_al),
      .load_i     (cnt_load),
      .load_val_i (WAIT_LOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Strobes are registered alongside the state so the SRAM pins never
   // see decode glitches; they are set on entry to ACCESS and cleared on exit.
   always_ff @(posedge Clk or negedge Reset_al) begin
      if (!Reset_al) begin
         state_q  <= ST_IDLE;
         mar_q    <= '0;
         mdr_q    <= '0;
         we_q     <= 1'b0;
         mdr_in_q <= '0;
         hex_q    <= '0;
         r_q      <= 1'b0;
         ce_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
      end else begin
         r_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.MEM_EN) begin
                  mar_q <= bus.MAR;
                  mdr_q <= bus.MDR;
                  we_q  <= bus.WE;
                  if (is_io) begin
                     // I/O port completes at the accepting edge itself.
                     if (bus.WE) begin
                        hex_q <= bus.MDR;
                     end else begin
                        mdr_in_q <= Switches;
                     end
                     r_q     <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     ce_n_q  <= 1'b0;
                     oe_n_q  <= bus.WE;
                     we_n_q  <= !bus.WE;
                     state_q <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               // MEM_EN is deliberately ignored here: an accepted access
               // always runs to completion.
               if (cnt_zero) begin
                  if (!we_q) begin
                     mdr_in_q <= Data_from_SRAM;
                  end
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
                  r_q     <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= bus.MEM_EN ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
               // A request level still high after R must not be served again.
               if (!bus.MEM_EN) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.MDR_In   = mdr_in_q;
   assign bus.R        = r_q;
   assign HEX_Data     = hex_q;
   assign ADDR         = {4'b0000, mar_q};
   assign Data_to_SRAM = mdr_q;
   assign CE_N         = ce_n_q;
   assign OE_N         = oe_n_q;
   assign WE_N         = we_n_q;
   assign UB_N         = ce_n_q;
   assign LB_N         = ce_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder (WAIT_CYCLES=2).
// A behavioural SRAM answers the DUT pins; a transaction-level model
// (memory array, hex register, last read value) predicts results.
module tb_mem_responder;

   localparam int          W  = 2;
   localparam logic [15:0] IO = 16'hFFFF;

   logic        clk;
   logic        rst_n;
   logic [15:0] Switches;
   logic [15:0] HEX_Data;
   logic [19:0] ADDR;
   logic [15:0] Data_to_SRAM;
   logic [15:0] Data_from_SRAM;
   logic        CE_N, OE_N, WE_N, UB_N, LB_N;
   logic        init_done;

   mem_responder_if bus();

   mem_responder #(.WAIT_CYCLES(W), .IO_ADDR(IO)) dut (
      .Clk            (clk),
      .Reset_al       (rst_n),
      .bus            (bus),
      .Switches       (Switches),
      .HEX_Data       (HEX_Data),
      .ADDR           (ADDR),
      .Data_to_SRAM   (Data_to_SRAM),
      .Data_from_SRAM (Data_from_SRAM),
      .CE_N           (CE_N),
      .OE_N           (OE_N),
      .WE_N           (WE_N),
      .UB_N           (UB_N),
      .LB_N           (LB_N)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input logic [7:0] a);
      return (a == 8'h40) ? 16'h1234 : ({8'h00, a} ^ 16'hA5C3);
   endfunction

   // Behavioural SRAM: 256 words indexed by the low address byte.
   logic [15:0] sram [256];
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) sram[i] <= init_val(8'(i));
      end else if (!CE_N && !WE_N) begin
         sram[ADDR[7:0]] <= Data_to_SRAM;
      end
   end
   always_comb begin
      Data_from_SRAM = 16'hDEAD;
      if (!CE_N && !OE_N) Data_from_SRAM = sram[ADDR[7:0]];
   end

   // Transaction-level reference model.
   logic [15:0] m_mem [256];
   logic [15:0] m_hex;
   logic [15:0] m_mdr;

   task automatic model(input logic [15:0] a, input logic [15:0] d, input logic w,
                        input logic [15:0] sw, output int lat,
                        output logic [15:0] emdr, output logic [15:0] ehex);
      if (a == IO) begin
         lat = 1;
         if (w) m_hex = d; else m_mdr = sw;
      end else begin
         lat = W + 1;
         if (w) m_mem[a[7:0]] = d; else m_mdr = m_mem[a[7:0]];
      end
      emdr = m_mdr;
      ehex = m_hex;
   endtask

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and observe a fixed window of cycles.
   task automatic do_txn(input logic [15:0] a, input logic [15:0] d, input logic w,
                         input logic [15:0] sw, input bit hold, input bit scramble,
                         input int exp_lat, input logic [15:0] exp_mdr,
                         input logic [15:0] exp_hex, input string tag);
      int          lat, rcnt, ce_cnt, oe_cnt, we_cnt, bad_addr, bad_data, bad_bl;
      logic [15:0] mdr_r, hex_r;
      logic [19:0] addr_r;
      bit          io;
      io = (a == IO);
      lat = -1; rcnt = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0;
      bad_addr = 0; bad_data = 0; bad_bl = 0;
      mdr_r = 16'h0; hex_r = 16'h0; addr_r = 20'h0;
      Switches = sw; bus.MAR = a; bus.MDR = d; bus.WE = w; bus.MEM_EN = 1'b1;
      for (int c = 1; c <= W + 5; c++) begin
         step();
         if (c == 1) begin
            if (!hold) bus.MEM_EN = 1'b0;
            if (scramble) begin
               bus.MAR = 16'($urandom); bus.MDR = 16'($urandom);
               bus.WE = 1'($urandom); Switches = 16'($urandom);
            end
         end
         if (bus.R) begin
            rcnt++;
            if (lat < 0) begin
               lat = c; mdr_r = bus.MDR_In; hex_r = HEX_Data; addr_r = ADDR;
            end
            bus.MEM_EN = 1'b0;
         end
         if (!CE_N) begin
            ce_cnt++;
            if (ADDR != {4'h0, a}) bad_addr++;
         end
         if (UB_N != CE_N || LB_N != CE_N) bad_bl++;
         if (!CE_N && !OE_N) oe_cnt++;
         if (!CE_N && !WE_N) begin
            we_cnt++;
            if (Data_to_SRAM != d) bad_data++;
         end
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " R pulses"}, rcnt, 1);
      chk({tag, " CE cycles"}, ce_cnt, io ? 0 : W);
      chk({tag, " OE cycles"}, oe_cnt, (!io && !w) ? W : 0);
      chk({tag, " WE cycles"}, we_cnt, (!io && w) ? W : 0);
      chk({tag, " ADDR during access"}, bad_addr, 0);
      chk({tag, " write data"}, bad_data, 0);
      chk({tag, " UB/LB"}, bad_bl, 0);
      chk({tag, " ADDR at R"}, addr_r, {4'h0, a});
      chk({tag, " MDR_In at R"}, mdr_r, exp_mdr);
      chk({tag, " HEX_Data at R"}, hex_r, exp_hex);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic        we;
      logic [15:0] sw;
      int          lat;
      logic [15:0] mdr;
      logic [15:0] hex;
   } vec_t;

   vec_t vt[6];

   initial begin
      int          lat, rcnt, ce_cnt;
      logic [15:0] emdr, ehex, a, d, sw;
      logic        w;

      vt[0] = '{16'h0040, 16'h0000, 1'b0, 16'h0000, 3, 16'h1234, 16'h0000};
      vt[1] = '{16'h0041, 16'hBEEF, 1'b1, 16'h0000, 3, 16'h1234, 16'h0000};
      vt[2] = '{16'hFFFF, 16'h00A5, 1'b1, 16'h0000, 1, 16'h1234, 16'h00A5};
      vt[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'h0F0F, 1, 16'h0F0F, 16'h00A5};
      vt[4] = '{16'h0041, 16'h0000, 1'b0, 16'h0000, 3, 16'hBEEF, 16'h00A5};
      vt[5] = '{16'h0010, 16'h0000, 1'b0, 16'hFFFF, 3, 16'hA5D3, 16'h00A5};

      for (int i = 0; i < 256; i++) m_mem[i] = init_val(8'(i));
      m_hex = 16'h0; m_mdr = 16'h0;

      rst_n = 1'b0; init_done = 1'b0;
      bus.MAR = 16'h0; bus.MDR = 16'h0; bus.WE = 1'b0; bus.MEM_EN = 1'b0;
      Switches = 16'h0;

      // Reset state
      step(); step();
      init_done = 1'b1;
      chk("reset CE_N", CE_N, 1); chk("reset OE_N", OE_N, 1);
      chk("reset WE_N", WE_N, 1); chk("reset UB_N", UB_N, 1);
      chk("reset LB_N", LB_N, 1); chk("reset R", bus.R, 0);
      chk("reset MDR_In", bus.MDR_In, 16'h0); chk("reset HEX_Data", HEX_Data, 16'h0);
      chk("reset ADDR", ADDR, 20'h0); chk("reset Data_to_SRAM", Data_to_SRAM, 16'h0);
      step();
      rst_n = 1'b1;
      step();

      // Directed table
      for (int i = 0; i < 6; i++) begin
         model(vt[i].addr, vt[i].data, vt[i].we, vt[i].sw, lat, emdr, ehex);
         do_txn(vt[i].addr, vt[i].data, vt[i].we, vt[i].sw, 1'b0, 1'b0,
                vt[i].lat, vt[i].mdr, vt[i].hex, $sformatf("vec%0d", i));
      end

      // MEM_EN held high for 10 cycles on one read
      rcnt = 0; ce_cnt = 0;
      bus.MAR = 16'h0040; bus.WE = 1'b0; bus.MEM_EN = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (bus.R) rcnt++;
         if (!CE_N) ce_cnt++;
      end
      bus.MEM_EN = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (bus.R) rcnt++;
         if (!CE_N) ce_cnt++;
      end
      model(16'h0040, 16'h0, 1'b0, 16'h0, lat, emdr, ehex);
      chk("hold R pulses", rcnt, 1);
      chk("hold CE cycles", ce_cnt, W);
      chk("hold MDR_In", bus.MDR_In, emdr);
      model(IO, 16'h5A5A, 1'b1, 16'h0, lat, emdr, ehex);
      do_txn(IO, 16'h5A5A, 1'b1, 16'h0, 1'b0, 1'b0, lat, emdr, ehex, "after_hold");

      // Reset in the second ACCESS cycle of a write; the data written equals
      // what the model already holds, so a partial write is harmless.
      d = m_mem[8'h42];
      bus.MAR = 16'h0042; bus.MDR = d; bus.WE = 1'b1; bus.MEM_EN = 1'b1;
      step();
      bus.MEM_EN = 1'b0;
      step();
      chk("midreset WE_N before", WE_N, 0);
      rst_n = 1'b0;
      #1;
      chk("midreset WE_N", WE_N, 1); chk("midreset CE_N", CE_N, 1);
      chk("midreset OE_N", OE_N, 1); chk("midreset R", bus.R, 0);
      chk("midreset HEX_Data", HEX_Data, 16'h0);
      chk("midreset MDR_In", bus.MDR_In, 16'h0);
      step();
      chk("midreset R held", bus.R, 0);
      rst_n = 1'b1;
      m_hex = 16'h0; m_mdr = 16'h0;
      step();
      model(16'h0041, 16'h0, 1'b0, 16'h0, lat, emdr, ehex);
      do_txn(16'h0041, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, lat, emdr, ehex, "after_reset");

      // Randomized transactions against the model
      for (int i = 0; i < 40; i++) begin
         a  = ($urandom_range(0, 3) == 0) ? IO : {8'h00, 8'($urandom)};
         d  = 16'($urandom);
         w  = 1'($urandom);
         sw = 16'($urandom);
         model(a, d, w, sw, lat, emdr, ehex);
         do_txn(a, d, w, sw, 1'($urandom), 1'b1, lat, emdr, ehex, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
